// File: rtl/demux_slot_sequencer.sv
// Serialises a latched 4-bit word onto the 1-to-4 demuxer: each enabled channel is
// driven for HOLD_CYCLES cycles in ascending order, followed by GAP_CYCLES idle cycles.
module demux_slot_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [3:0] in_mask,
  output logic       ser_out,
  output logic [1:0] sel,
  output logic       slot_valid,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_RELOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [3:0]        data_q, data_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        chan_q, chan_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              ser_out_q, ser_out_d;
  logic [1:0]        sel_q, sel_d;
  logic              slot_valid_q, slot_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic [2:0]        first_hit;
  logic [2:0]        next_hit;

  // Handshake: a word transfers on the rising edge where in_valid and in_ready are
  // both high; in_ready is high only in IDLE while rst is low, and in_valid may be
  // held or changed freely since only the accepting edge latches in_data/in_mask.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Lowest set mask bit at or above lo; result is {found, channel}.
  function automatic logic [2:0] first_at_or_above(input logic [3:0] mask, input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= lo)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign first_hit = first_at_or_above(in_mask, 3'd0);
  assign next_hit  = first_at_or_above(mask_q, {1'b0, chan_q} + 3'd1);

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mask_d       = mask_q;
    chan_d       = chan_q;
    hold_d       = hold_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d = in_data;
          mask_d = in_mask;
          if (first_hit[2]) begin
            state_d = ST_SLOT;
            chan_d  = first_hit[1:0];
            hold_d  = HOLD_RELOAD;
          end else begin
            frame_done_d = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_RELOAD;
            end
          end
        end
      end
      ST_SLOT: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (next_hit[2]) begin
          chan_d = next_hit[1:0];
          hold_d = HOLD_RELOAD;
        end else begin
          frame_done_d = 1'b1;
          state_d      = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          gap_d        = GAP_RELOAD;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state.
    busy_d       = (state_d != ST_IDLE);
    slot_valid_d = (state_d == ST_SLOT);
    sel_d        = slot_valid_d ? chan_d : 2'd0;
    ser_out_d    = slot_valid_d ? data_d[chan_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      mask_q       <= '0;
      chan_q       <= '0;
      hold_q       <= '0;
      gap_q        <= '0;
      ser_out_q    <= 1'b0;
      sel_q        <= 2'd0;
      slot_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      chan_q       <= chan_d;
      hold_q       <= hold_d;
      gap_q        <= gap_d;
      ser_out_q    <= ser_out_d;
      sel_q        <= sel_d;
      slot_valid_q <= slot_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign sel        = sel_q;
  assign slot_valid = slot_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_slot_sequencer.sv
// Directed bench: one instance with default timing (HOLD=2, GAP=1) and one with
// GAP_CYCLES=0 for the back-to-back case; all expectations are hand-computed.
module tb_demux_slot_sequencer;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready;
  logic [3:0] in_data, in_mask;
  logic       ser_out, slot_valid, busy, frame_done;
  logic [1:0] sel;

  logic       v0, r0;
  logic [3:0] d0, m0;
  logic       ser0, sv0, busy0, fd0;
  logic [1:0] sel0;

  int checks   = 0;
  int failures = 0;

  demux_slot_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .ser_out(ser_out), .sel(sel), .slot_valid(slot_valid), .busy(busy), .frame_done(frame_done)
  );

  demux_slot_sequencer #(.HOLD_CYCLES(2), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(v0), .in_ready(r0), .in_data(d0), .in_mask(m0),
    .ser_out(ser0), .sel(sel0), .slot_valid(sv0), .busy(busy0), .frame_done(fd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_slot_valid"}, {7'd0, slot_valid}, 8'd0);
    check({tag, "_sel"},        {6'd0, sel},        8'd0);
    check({tag, "_ser_out"},    {7'd0, ser_out},    8'd0);
  endtask

  task automatic check_slot(input string tag, input logic [1:0] esel, input logic eser);
    check({tag, "_slot_valid"}, {7'd0, slot_valid}, 8'd1);
    check({tag, "_sel"},        {6'd0, sel},        {6'd0, esel});
    check({tag, "_ser_out"},    {7'd0, ser_out},    {7'd0, eser});
    check({tag, "_busy"},       {7'd0, busy},       8'd1);
    check({tag, "_frame_done"}, {7'd0, frame_done}, 8'd0);
    check({tag, "_in_ready"},   {7'd0, in_ready},   8'd0);
  endtask

  task automatic check_slot0(input string tag, input logic [1:0] esel, input logic eser);
    check({tag, "_slot_valid"}, {7'd0, sv0},  8'd1);
    check({tag, "_sel"},        {6'd0, sel0}, {6'd0, esel});
    check({tag, "_ser_out"},    {7'd0, ser0}, {7'd0, eser});
    check({tag, "_frame_done"}, {7'd0, fd0},  8'd0);
    check({tag, "_in_ready"},   {7'd0, r0},   8'd0);
  endtask

  logic [1:0] full_sel [8];
  logic       full_ser [8];

  initial begin
    full_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    full_ser = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held 3 cycles with a valid word pending on both instances.
    rst = 1'b1;
    in_valid = 1'b1; in_data = 4'b1111; in_mask = 4'b1111;
    v0 = 1'b1; d0 = 4'b1111; m0 = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("rst");
      check("rst_busy",       {7'd0, busy},       8'd0);
      check("rst_frame_done", {7'd0, frame_done}, 8'd0);
      check("rst_in_ready",   {7'd0, in_ready},   8'd0);
      check("rst_busy0",      {7'd0, busy0},      8'd0);
      check("rst_in_ready0",  {7'd0, r0},         8'd0);
    end
    rst = 1'b0; in_valid = 1'b0; v0 = 1'b0;
    #1;
    check("rst_release_in_ready",  {7'd0, in_ready}, 8'd1);
    check("rst_release_in_ready0", {7'd0, r0},       8'd1);
    tick();
    check("rst_nothing_taken", {7'd0, busy}, 8'd0);

    // Full frame; in_data is scrambled right after accept and must not matter.
    in_valid = 1'b1; in_data = 4'b1011; in_mask = 4'b1111;
    tick();
    in_valid = 1'b0; in_data = 4'b0100; in_mask = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      check_slot($sformatf("full_%0d", k), full_sel[k], full_ser[k]);
      tick();
    end
    check_quiet("full_gap");
    check("full_frame_done", {7'd0, frame_done}, 8'd1);
    check("full_gap_busy",   {7'd0, busy},       8'd1);
    check("full_gap_ready",  {7'd0, in_ready},   8'd0);
    tick();
    check("full_idle_ready", {7'd0, in_ready},   8'd1);
    check("full_fd_clear",   {7'd0, frame_done}, 8'd0);
    check("full_idle_busy",  {7'd0, busy},       8'd0);

    // Sparse mask: only channels 1 and 3.
    in_valid = 1'b1; in_data = 4'b0110; in_mask = 4'b1010;
    tick();
    in_valid = 1'b0;
    check_slot("sparse_0", 2'd1, 1'b1);
    tick();
    check_slot("sparse_1", 2'd1, 1'b1);
    tick();
    check_slot("sparse_2", 2'd3, 1'b0);
    tick();
    check_slot("sparse_3", 2'd3, 1'b0);
    tick();
    check_quiet("sparse_gap");
    check("sparse_frame_done", {7'd0, frame_done}, 8'd1);
    tick();
    check("sparse_ready", {7'd0, in_ready}, 8'd1);

    // Empty mask, twice in a row at the earliest legal spacing.
    in_valid = 1'b1; in_data = 4'b1111; in_mask = 4'b0000;
    tick();
    check_quiet("empty_n1");
    check("empty_frame_done", {7'd0, frame_done}, 8'd1);
    check("empty_busy",       {7'd0, busy},       8'd1);
    check("empty_ready_n1",   {7'd0, in_ready},   8'd0);
    tick();
    check_quiet("empty_n2");
    check("empty_ready_n2", {7'd0, in_ready},   8'd1);
    check("empty_fd_clear", {7'd0, frame_done}, 8'd0);
    tick();
    in_valid = 1'b0;
    check("empty2_frame_done", {7'd0, frame_done}, 8'd1);
    check("empty2_slot_valid", {7'd0, slot_valid}, 8'd0);
    tick();
    tick();
    check("empty2_idle_busy", {7'd0, busy}, 8'd0);

    // Back-to-back with GAP_CYCLES=0, in_valid held high across both words.
    v0 = 1'b1; d0 = 4'b0011; m0 = 4'b0011;
    tick();
    d0 = 4'b1100; m0 = 4'b1000;
    check_slot0("b2b_a0", 2'd0, 1'b1);
    tick();
    check_slot0("b2b_a1", 2'd0, 1'b1);
    tick();
    check_slot0("b2b_a2", 2'd1, 1'b1);
    tick();
    check_slot0("b2b_a3", 2'd1, 1'b1);
    tick();
    check("b2b_fd",         {7'd0, fd0}, 8'd1);
    check("b2b_ready_same", {7'd0, r0},  8'd1);
    check("b2b_sv_idle",    {7'd0, sv0}, 8'd0);
    tick();
    v0 = 1'b0;
    check_slot0("b2b_b0", 2'd3, 1'b1);
    tick();
    check_slot0("b2b_b1", 2'd3, 1'b1);
    tick();
    check("b2b_b_fd",    {7'd0, fd0},   8'd1);
    check("b2b_b_ready", {7'd0, r0},    8'd1);
    tick();
    check("b2b_end_fd",   {7'd0, fd0},   8'd0);
    check("b2b_end_busy", {7'd0, busy0}, 8'd0);

    // Reset in the sel=2 slot drops the frame without frame_done.
    in_valid = 1'b1; in_data = 4'b1011; in_mask = 4'b1111;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_slot($sformatf("mid_%0d", k), full_sel[k], full_ser[k]);
      if (k < 4) tick();
    end
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {7'd0, in_ready}, 8'd0);
    tick();
    rst = 1'b0;
    check_quiet("mid_after_rst");
    check("mid_busy",       {7'd0, busy},       8'd0);
    check("mid_frame_done", {7'd0, frame_done}, 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_no_fd_%0d", k), {7'd0, frame_done}, 8'd0);
    end
    check("mid_ready", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1; in_data = 4'b0101; in_mask = 4'b0100;
    tick();
    in_valid = 1'b0;
    check_slot("post_0", 2'd2, 1'b1);
    tick();
    check_slot("post_1", 2'd2, 1'b1);
    tick();
    check("post_frame_done", {7'd0, frame_done}, 8'd1);
    tick();
    check("post_ready", {7'd0, in_ready}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
